// File: rtl/dev_bus_pkg.sv
// Shared definitions for the processor-side bus arbiter and its neighbours:
// sequencer states, device window defaults, timer base addresses and the
// latched request record.
package dev_bus_pkg;

    // Sequencer states. Every accepted request walks IDLE -> ACCESS -> RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Default device window (inclusive on both ends).
    localparam logic [31:0] DEV_BASE_DEFAULT  = 32'h0000_7F00;
    localparam logic [31:0] DEV_LIMIT_DEFAULT = 32'h0000_7F1F;

    // Timer register blocks inside the device window.
    localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;

    // Master identifiers as carried on the grant id.
    localparam logic MID_M0 = 1'b0;
    localparam logic MID_M1 = 1'b1;

    // One master's request as captured at grant time.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        we;
    } bus_req_t;

    // True when addr lies inside [base, limit].
    function automatic logic in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] limit
    );
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant decision. Purely combinational: the caller samples the
// result only while it is ready to accept a new request.
module rr_arb2
    import dev_bus_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    // Pick a winner: a lone requester always wins; a tie goes to master 0
    // under fixed priority, otherwise to whoever was not served last.
    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        gnt_valid_o = req0_i | req1_i;
        gnt_id_o    = MID_M0;
        if (req0_i && req1_i) begin
            gnt_id_o = FIXED_PRIO ? MID_M0 : ~last_grant_i;
        end else if (req1_i) begin
            gnt_id_o = MID_M1;
        end
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master arbiter and sequencer in front of the system bridge's
// processor-side port. One request is granted at a time, driven onto the
// bridge for exactly one cycle, and answered with a one-cycle ack carrying
// read data and an out-of-window error flag.
module dev_bus_arbiter
    import dev_bus_pkg::*;
#(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter logic [31:0] DEV_BASE   = DEV_BASE_DEFAULT,
    parameter logic [31:0] DEV_LIMIT  = DEV_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    // Master 0: CPU memory stage
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic [3:0]  m0_be,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rd,

    // Master 1: DMA / debug loader
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic [3:0]  m1_be,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rd,

    // Bridge processor-side port
    output logic [31:0] pr_addr,
    output logic [31:0] pr_wd,
    output logic [3:0]  pr_be,
    output logic        pr_we,
    input  logic [31:0] pr_rd
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e      state_q,      state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_id_q,     gnt_id_d;
    logic        in_range_q,   in_range_d;
    bus_req_t    req_q,        req_d;
    logic [31:0] m0_rd_q,      m0_rd_d;
    logic [31:0] m1_rd_q,      m1_rd_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic     gnt_valid;
    logic     gnt_id;
    bus_req_t m0_fields;
    bus_req_t m1_fields;
    bus_req_t sel_fields;
    logic     sel_in_range;
    logic     access_active;
    logic [31:0] rd_capture;

    assign m0_fields = {m0_addr, m0_wd, m0_be, m0_we};
    assign m1_fields = {m1_addr, m1_wd, m1_be, m1_we};

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .req0_i       (m0_req),
        .req1_i       (m1_req),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    // Fields of the master that would be granted this cycle; the other
    // master's fields never reach the latch.
    assign sel_fields   = (gnt_id == MID_M1) ? m1_fields : m0_fields;
    assign sel_in_range = in_window(sel_fields.addr, DEV_BASE, DEV_LIMIT);

    // Out-of-window reads return zero instead of whatever the bridge mux
    // happens to present.
    assign rd_capture    = in_range_q ? pr_rd : 32'h0;
    assign access_active = (state_q == ACCESS);

    // ------------------------------------------------------------------
    // Next-state logic: grant and latch in IDLE, capture read data in
    // ACCESS, acknowledge in RESP. All registers hold unless told otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        in_range_d   = in_range_q;
        req_d        = req_q;
        m0_rd_d      = m0_rd_q;
        m1_rd_d      = m1_rd_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d      = ACCESS;
                    gnt_id_d     = gnt_id;
                    last_grant_d = gnt_id;
                    req_d        = sel_fields;
                    in_range_d   = sel_in_range;
                end
            end

            ACCESS: begin
                // Bridge data lands straight in the granted master's read
                // register, so it is valid during RESP and held until that
                // master's next ack.
                state_d = RESP;
                if (gnt_id_q == MID_M1) begin
                    m1_rd_d = rd_capture;
                end else begin
                    m0_rd_d = rd_capture;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; an in-flight transfer is
    // dropped without an ack.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values, independent of statement order.
        if (reset) begin
            // NOTE: only flip-flops here, no memories; each one gets a defined
            // reset value so the bridge sees a clean idle bus after reset.
            state_q      <= IDLE;
            last_grant_q <= MID_M1;
            gnt_id_q     <= MID_M0;
            in_range_q   <= 1'b0;
            req_q        <= '0;
            m0_rd_q      <= 32'h0;
            m1_rd_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            in_range_q   <= in_range_d;
            req_q        <= req_d;
            m0_rd_q      <= m0_rd_d;
            m1_rd_q      <= m1_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Address, data and byte enables come from the latch, so they
    // stay stable outside ACCESS; the write strobe is gated to ACCESS and to
    // in-window addresses only.
    // ------------------------------------------------------------------
    assign pr_addr = req_q.addr;
    assign pr_wd   = req_q.wd;
    assign pr_be   = req_q.be;
    assign pr_we   = access_active & req_q.we & in_range_q;

    assign m0_ack  = (state_q == RESP) & (gnt_id_q == MID_M0);
    assign m1_ack  = (state_q == RESP) & (gnt_id_q == MID_M1);
    assign m0_err  = m0_ack & ~in_range_q;
    assign m1_err  = m1_ack & ~in_range_q;
    assign m0_rd   = m0_rd_q;
    assign m1_rd   = m1_rd_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter. Two instances run side by side:
// index 0 uses round-robin ties, index 1 uses fixed priority. A transfer-level
// model predicts every output on every cycle; directed tests add literal
// expectations for latency, ordering and window handling.
`timescale 1ns/1ps
module tb_dev_bus_arbiter;
    import dev_bus_pkg::*;

    localparam int NI = 2;
    localparam logic [31:0] WIN_LO = 32'h0000_7F00;
    localparam logic [31:0] WIN_HI = 32'h0000_7F1F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // DUT signals, one slot per instance
    logic        reset   [NI];
    logic        m0_req  [NI];
    logic [31:0] m0_addr [NI];
    logic [31:0] m0_wd   [NI];
    logic [3:0]  m0_be   [NI];
    logic        m0_we   [NI];
    logic        m0_ack  [NI];
    logic        m0_err  [NI];
    logic [31:0] m0_rd   [NI];
    logic        m1_req  [NI];
    logic [31:0] m1_addr [NI];
    logic [31:0] m1_wd   [NI];
    logic [3:0]  m1_be   [NI];
    logic        m1_we   [NI];
    logic        m1_ack  [NI];
    logic        m1_err  [NI];
    logic [31:0] m1_rd   [NI];
    logic [31:0] pr_addr [NI];
    logic [31:0] pr_wd   [NI];
    logic [3:0]  pr_be   [NI];
    logic        pr_we   [NI];
    logic [31:0] pr_rd   [NI];

    dev_bus_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset[0]),
        .m0_req(m0_req[0]), .m0_addr(m0_addr[0]), .m0_wd(m0_wd[0]), .m0_be(m0_be[0]), .m0_we(m0_we[0]),
        .m0_ack(m0_ack[0]), .m0_err(m0_err[0]), .m0_rd(m0_rd[0]),
        .m1_req(m1_req[0]), .m1_addr(m1_addr[0]), .m1_wd(m1_wd[0]), .m1_be(m1_be[0]), .m1_we(m1_we[0]),
        .m1_ack(m1_ack[0]), .m1_err(m1_err[0]), .m1_rd(m1_rd[0]),
        .pr_addr(pr_addr[0]), .pr_wd(pr_wd[0]), .pr_be(pr_be[0]), .pr_we(pr_we[0]), .pr_rd(pr_rd[0])
    );

    dev_bus_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset[1]),
        .m0_req(m0_req[1]), .m0_addr(m0_addr[1]), .m0_wd(m0_wd[1]), .m0_be(m0_be[1]), .m0_we(m0_we[1]),
        .m0_ack(m0_ack[1]), .m0_err(m0_err[1]), .m0_rd(m0_rd[1]),
        .m1_req(m1_req[1]), .m1_addr(m1_addr[1]), .m1_wd(m1_wd[1]), .m1_be(m1_be[1]), .m1_we(m1_we[1]),
        .m1_ack(m1_ack[1]), .m1_err(m1_err[1]), .m1_rd(m1_rd[1]),
        .pr_addr(pr_addr[1]), .pr_wd(pr_wd[1]), .pr_be(pr_be[1]), .pr_we(pr_we[1]), .pr_rd(pr_rd[1])
    );

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_obs(input string name, input logic [136:0] act, input logic [136:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transfer-level model. A transfer accepted in cycle A shows its bridge
    // access in cycle A+1 and its ack in cycle A+2; no new grant happens
    // before cycle A+3.
    // ------------------------------------------------------------------
    bit          ok     [NI] = '{1'b0, 1'b0};
    bit          active [NI] = '{1'b0, 1'b0};
    bit          last   [NI] = '{1'b1, 1'b1};
    bit          mg     [NI] = '{1'b0, 1'b0};
    bit          minr   [NI] = '{1'b0, 1'b0};
    int          acc    [NI] = '{0, 0};
    logic        e_ack0 [NI];
    logic        e_ack1 [NI];
    logic        e_err0 [NI];
    logic        e_err1 [NI];
    logic        e_we   [NI];
    logic [31:0] e_rd0  [NI];
    logic [31:0] e_rd1  [NI];
    logic [31:0] e_addr [NI];
    logic [31:0] e_wd   [NI];
    logic [3:0]  e_be   [NI];

    function automatic logic [136:0] dut_obs(input int i);
        return {m0_ack[i], m1_ack[i], m0_err[i], m1_err[i], m0_rd[i], m1_rd[i],
                pr_addr[i], pr_wd[i], pr_be[i], pr_we[i]};
    endfunction

    function automatic logic [136:0] mdl_obs(input int i);
        return {e_ack0[i], e_ack1[i], e_err0[i], e_err1[i], e_rd0[i], e_rd1[i],
                e_addr[i], e_wd[i], e_be[i], e_we[i]};
    endfunction

    // Predict the outputs after the coming edge from the inputs seen now.
    task automatic model_step(input int i);
        bit          pick;
        logic [31:0] a;
        logic [31:0] data;
        if (!reset[i] && !ok[i]) return;
        e_ack0[i] = 1'b0;
        e_ack1[i] = 1'b0;
        e_err0[i] = 1'b0;
        e_err1[i] = 1'b0;
        e_we[i]   = 1'b0;
        if (reset[i]) begin
            ok[i]     = 1'b1;
            active[i] = 1'b0;
            last[i]   = 1'b1;
            e_rd0[i]  = 32'h0;
            e_rd1[i]  = 32'h0;
            e_addr[i] = 32'h0;
            e_wd[i]   = 32'h0;
            e_be[i]   = 4'h0;
        end else if (active[i] && cyc == acc[i] + 1) begin
            data = minr[i] ? pr_rd[i] : 32'h0;
            if (mg[i]) begin
                e_ack1[i] = 1'b1;
                e_err1[i] = !minr[i];
                e_rd1[i]  = data;
            end else begin
                e_ack0[i] = 1'b1;
                e_err0[i] = !minr[i];
                e_rd0[i]  = data;
            end
        end else if (active[i] && cyc == acc[i] + 2) begin
            active[i] = 1'b0;
        end else if (m0_req[i] || m1_req[i]) begin
            if (m0_req[i] && m1_req[i]) pick = (i == 1) ? 1'b0 : !last[i];
            else                        pick = m1_req[i];
            a         = pick ? m1_addr[i] : m0_addr[i];
            minr[i]   = (a >= WIN_LO) && (a <= WIN_HI);
            e_addr[i] = a;
            e_wd[i]   = pick ? m1_wd[i] : m0_wd[i];
            e_be[i]   = pick ? m1_be[i] : m0_be[i];
            e_we[i]   = (pick ? m1_we[i] : m0_we[i]) & minr[i];
            last[i]   = pick;
            mg[i]     = pick;
            active[i] = 1'b1;
            acc[i]    = cyc;
        end
    endtask

    // Logs of acks and bridge writes for the directed literal checks.
    typedef struct {
        int          m;
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } ack_t;
    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wd;
    } wr_t;
    ack_t alog[$];
    wr_t  wlog[$];

    // Compare on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ok[i]) check_obs($sformatf("inst%0d_outputs_cyc%0d", i, cyc), dut_obs(i), mdl_obs(i));
            if (m0_ack[i] === 1'b1) alog.push_back('{0, cyc, m0_rd[i], m0_err[i]});
            if (m1_ack[i] === 1'b1) alog.push_back('{1, cyc, m1_rd[i], m1_err[i]});
            if (pr_we[i] === 1'b1)  wlog.push_back('{cyc, pr_addr[i], pr_wd[i]});
            model_step(i);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input int m, input bit req, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input bit we);
        if (m == 0) begin
            m0_req[i] = req; m0_addr[i] = addr; m0_wd[i] = wd; m0_be[i] = be; m0_we[i] = we;
        end else begin
            m1_req[i] = req; m1_addr[i] = addr; m1_wd[i] = wd; m1_be[i] = be; m1_we[i] = we;
        end
    endtask

    task automatic do_reset(input int i);
        tick();
        reset[i] = 1'b1;
        tick();
        tick();
        reset[i] = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int k = 0;
        while (alog.size() < n && k < budget) begin
            tick();
            k++;
        end
        check32({name, "_ack_count"}, 32'(alog.size() >= n), 32'd1);
    endtask

    task automatic clear_logs();
        alog.delete();
        wlog.delete();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int start;
        int exp_cyc [4] = '{2, 5, 8, 11};
        int exp_m   [4] = '{0, 1, 0, 1};

        for (int i = 0; i < NI; i++) begin
            reset[i] = 1'b1;
            pr_rd[i] = 32'h0;
            set_m(i, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
            set_m(i, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        end
        repeat (3) tick();
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Reset state
        check32("reset_m0_rd",   m0_rd[0], 32'h0);
        check32("reset_m1_rd",   m1_rd[0], 32'h0);
        check32("reset_pr_addr", pr_addr[0], 32'h0);
        check32("reset_pr_be",   32'(pr_be[0]), 32'h0);
        check32("reset_pr_we",   32'(pr_we[0]), 32'h0);
        check32("reset_acks",    32'({m0_ack[0], m1_ack[0], m0_err[0], m1_err[0]}), 32'h0);

        // Single read by master 0
        tick();
        clear_logs();
        pr_rd[0] = 32'h1234_5678;
        set_m(0, 0, 1'b1, 32'h0000_7F04, 32'h0, 4'hF, 1'b0);
        start = cyc;
        wait_acks(1, 10, "rd");
        set_m(0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        if (alog.size() > 0) begin
            check32("rd_master",  32'(alog[0].m), 32'd0);
            check32("rd_latency", 32'(alog[0].cyc - start), 32'd2);
            check32("rd_data",    alog[0].rd, 32'h1234_5678);
            check32("rd_err",     32'(alog[0].err), 32'd0);
        end
        check32("rd_no_write", 32'(wlog.size()), 32'd0);

        // Single write by master 1
        tick();
        clear_logs();
        set_m(0, 1, 1'b1, TIMER1_BASE, 32'hDEAD_BEEF, 4'b1111, 1'b1);
        start = cyc;
        wait_acks(1, 10, "wr");
        set_m(0, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check32("wr_strobe_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            check32("wr_strobe_cycle", 32'(wlog[0].cyc - start), 32'd1);
            check32("wr_addr",         wlog[0].addr, 32'h0000_7F10);
            check32("wr_data",         wlog[0].wd, 32'hDEAD_BEEF);
        end
        if (alog.size() > 0) begin
            check32("wr_master",  32'(alog[0].m), 32'd1);
            check32("wr_latency", 32'(alog[0].cyc - start), 32'd2);
            check32("wr_err",     32'(alog[0].err), 32'd0);
        end

        // Out-of-window write just above the limit, then a read of address 0
        tick();
        clear_logs();
        set_m(0, 0, 1'b1, 32'h0000_7F20, 32'h5555_AAAA, 4'hF, 1'b1);
        wait_acks(1, 10, "oow_wr");
        set_m(0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check32("oow_wr_no_strobe", 32'(wlog.size()), 32'd0);
        if (alog.size() > 0) begin
            check32("oow_wr_err", 32'(alog[0].err), 32'd1);
            check32("oow_wr_rd",  alog[0].rd, 32'h0);
        end

        tick();
        clear_logs();
        set_m(0, 0, 1'b1, 32'h0000_0000, 32'h0, 4'hF, 1'b0);
        wait_acks(1, 10, "oow_rd");
        set_m(0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check32("oow_rd_no_strobe", 32'(wlog.size()), 32'd0);
        if (alog.size() > 0) begin
            check32("oow_rd_err", 32'(alog[0].err), 32'd1);
            check32("oow_rd_rd",  alog[0].rd, 32'h0);
        end

        // Round-robin contention from a fresh reset
        do_reset(0);
        clear_logs();
        pr_rd[0] = 32'hA5A5_0F0F;
        set_m(0, 0, 1'b1, TIMER0_BASE, 32'h0, 4'hF, 1'b0);
        set_m(0, 1, 1'b1, 32'h0000_7F14, 32'h0, 4'hF, 1'b0);
        start = cyc;
        wait_acks(4, 20, "rr");
        set_m(0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_m(0, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (alog.size() > k) begin
                check32($sformatf("rr_order_%0d", k), 32'(alog[k].m), 32'(exp_m[k]));
                check32($sformatf("rr_cycle_%0d", k), 32'(alog[k].cyc - start), 32'(exp_cyc[k]));
            end
        end

        // Fixed priority: master 0 starves master 1 until it lets go
        tick();
        clear_logs();
        pr_rd[1] = 32'h0BAD_F00D;
        set_m(1, 0, 1'b1, 32'h0000_7F08, 32'h0, 4'hF, 1'b0);
        set_m(1, 1, 1'b1, 32'h0000_7F18, 32'h0, 4'hF, 1'b0);
        start = cyc;
        wait_acks(3, 20, "fp_m0");
        set_m(1, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (alog.size() > k) check32($sformatf("fp_m0_wins_%0d", k), 32'(alog[k].m), 32'd0);
        end
        wait_acks(4, 10, "fp_m1");
        set_m(1, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        if (alog.size() > 3) begin
            check32("fp_m1_master", 32'(alog[3].m), 32'd1);
            check32("fp_m1_cycle",  32'(alog[3].cyc - start), 32'd11);
        end

        // Reset during ACCESS of a write: no ack; first tie afterwards goes to m0
        tick();
        clear_logs();
        set_m(0, 0, 1'b1, 32'h0000_7F08, 32'hCAFE_0001, 4'hF, 1'b1);
        tick();
        reset[0] = 1'b1;
        set_m(0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();
        check32("rst_mid_state_no_ack", 32'(m0_ack[0]), 32'd0);
        check32("rst_mid_pr_we",        32'(pr_we[0]), 32'd0);
        tick();
        reset[0] = 1'b0;
        check32("rst_mid_ack_count",  32'(alog.size()), 32'd0);
        check32("rst_mid_write_seen", 32'(wlog.size()), 32'd1);
        tick();
        clear_logs();
        set_m(0, 0, 1'b1, TIMER0_BASE, 32'h0, 4'hF, 1'b0);
        set_m(0, 1, 1'b1, TIMER1_BASE, 32'h0, 4'hF, 1'b0);
        start = cyc;
        wait_acks(1, 10, "post_rst");
        set_m(0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_m(0, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        if (alog.size() > 0) begin
            check32("post_rst_tie_m0", 32'(alog[0].m), 32'd0);
            check32("post_rst_cycle",  32'(alog[0].cyc - start), 32'd2);
        end

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
